// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues word-aligned requests to instruction memory and buffers the returned
// words in a small prefetch queue whose head feeds the IF/ID register. A low
// 'valid' from EX squashes the queue and redirects fetch to 'target'; a
// response that was already in flight at that moment is waited for and dropped.
// Build option: define FETCH_PREFETCH_EN for a two-entry queue, so the next
// fetch can overlap a held instruction. Without it the queue holds one entry.

package fetch_pkg;
    typedef struct packed {
        logic [31:0] ia_plus_4;
        logic [31:0] ir;
    } id_params_t;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        valid,
    input  logic [31:0] target,
    input  logic        stall,
    output id_params_t  id_params_out,
    output logic        id_valid
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,     // no request outstanding
        ST_REQ,      // request outstanding, response will be kept
        ST_DISCARD   // request outstanding, response will be dropped
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_disc_addr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_wr_idx;
    id_params_t       r_queue [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic [31:0] w_pc_plus_4;
    logic [31:0] w_target_aligned;

    assign w_pc_plus_4      = r_pc + 32'd4;
    assign w_target_aligned = target & 32'hFFFF_FFFC;

    // A squash from EX overrides everything else in the cycle.
    assign w_flush  = ~valid;
    assign id_valid = (r_count != '0);
    assign w_pop    = id_valid & ~stall & valid;
    assign w_push   = (r_state == ST_REQ) & imem_ack & valid;
    // Pushes land behind whatever survives this cycle's pop.
    assign w_wr_idx = r_count - CNT_W'(w_pop);

    // The request address is held at the squashed pc while discarding so the
    // memory sees a stable transaction until it acknowledges.
    assign imem_req      = (r_state != ST_IDLE);
    assign imem_addr     = (r_state == ST_DISCARD) ? r_disc_addr : r_pc;
    assign id_params_out = id_valid ? r_queue[0] : '0;

    // Queue occupancy after this cycle's squash, push and pop.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Fetch state transitions.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (valid && (r_count < CNT_W'(DEPTH))) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!valid) begin
                    w_state_next = imem_ack ? ST_REQ : ST_DISCARD;
                end else if (imem_ack) begin
                    w_state_next = (w_count_next < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, pc, occupancy and the held address of a squashed request.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VECTOR & 32'hFFFF_FFFC;
            r_disc_addr <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_flush) begin
                r_pc <= w_target_aligned;
            end else if (w_push) begin
                r_pc <= w_pc_plus_4;
            end
            if ((r_state == ST_REQ) && w_flush && !imem_ack) begin
                r_disc_addr <= r_pc;
            end
        end
    end

    // Queue storage: shift toward the head on pop, write the new entry behind.
    // NOTE: queue storage is not reset; r_count gates it, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_queue[i] <= r_queue[i + 1];
            end
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == w_wr_idx) begin
                    r_queue[i] <= '{ia_plus_4: w_pc_plus_4, ir: imem_rdata};
                end
            end
        end
    end

endmodule
